// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared definitions for the 7-segment scan controller.
//   - register word addresses and CTRL bit positions
//   - scan FSM state type (OFF=0, SHOW=1, GAP=2, visible in STATUS[4:3])
//   - hex nibble to segment decode (bit0=a ... bit6=g, logical polarity)
package sevseg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = $clog2(MAX_DIGITS);

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_DIGITS   = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_RAW_BIT  = 1;
  localparam int CTRL_MASK_LSB = 8;
  localparam int CTRL_DIV_LSB  = 16;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/sevseg_scan_ctrl_if.sv
// sevseg_scan_ctrl_if: Avalon-MM register bus of the display controller.
//   address[1:0]    word address
//   chipselect      slave select
//   write_n         active-low write strobe
//   writedata[31:0] write data
//   readdata[31:0]  read data, combinational from address
// Transfer rule: a write is accepted on every rising clk edge where
// chipselect=1 and write_n=0 (no wait states, the slave is always ready);
// readdata is valid whenever address is stable, no read strobe is needed.
interface sevseg_scan_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface

// File: rtl/sevseg_dwell_timer.sv
// sevseg_dwell_timer: 16-bit down-counter shared by the SHOW dwell and the
// GAP blanking interval.
//   clk, reset_n  clock, asynchronous active-low reset
//   load_val      value loaded on load (interval length minus one)
//   load          load strobe
//   clear         forces the count to zero (priority over load)
//   done          high while the count has reached zero
module sevseg_dwell_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] load_val,
  input  logic        load,
  input  logic        clear,
  output logic        done
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 16'd1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl: Avalon-MM slave driving a multiplexed 7-segment bank.
// Digits are decoded from DIGITS nibbles and scanned round-robin with a
// blank gap between digits.
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           register bus (sevseg_scan_ctrl_if.slave)
//   seg_out[6:0]  segments a..g (inverted at the pin if SEG_ACTIVE_LOW)
//   digit_en      one-hot digit select (inverted if SEG_ACTIVE_LOW)
//   dbg_state     current scan state, for observation
// Optional feature macro: SEVSEG_BLINK_EN (per-digit blink mask in CTRL).
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int          NUM_DIGITS     = 4,
  parameter int          GAP_CYCLES     = 2,
  parameter int          SEG_ACTIVE_LOW = 0,
  parameter logic [15:0] PRESCALE_RST   = 16'd49999
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sevseg_scan_ctrl_if.slave     bus,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output scan_state_t           dbg_state
);

  localparam bit INV = (SEG_ACTIVE_LOW != 0);

  logic                    ctrl_en, ctrl_raw;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [15:0]             prescale_q;
  logic [31:0]             digits_ext;
  logic                    wr;
  logic                    unused_wdata;

  scan_state_t             state;
  logic [IDX_W-1:0]        index, next_index;
  logic [6:0]              seg_q, show_seg;
  logic [NUM_DIGITS-1:0]   digit_en_q;
  logic                    blink_phase;

  logic        t_load, t_clear, t_done;
  logic [15:0] t_val;

`ifdef SEVSEG_BLINK_EN
  logic [7:0]  blink_mask;
  logic [3:0]  blink_div;
  logic [15:0] frame_cnt;
`else
  assign blink_phase = 1'b0;
`endif

  assign wr           = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata;
  assign digits_ext   = 32'(digits_q);

  // Register file. The FSM samples these on the same edge a write lands,
  // so it always acts on the pre-write values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en    <= 1'b0;
      ctrl_raw   <= 1'b0;
      digits_q   <= '0;
      prescale_q <= PRESCALE_RST;
`ifdef SEVSEG_BLINK_EN
      blink_mask <= '0;
      blink_div  <= '0;
`endif
    end else if (wr) begin
      case (bus.address)
        ADDR_CTRL: begin
          ctrl_en  <= bus.writedata[CTRL_EN_BIT];
          ctrl_raw <= bus.writedata[CTRL_RAW_BIT];
`ifdef SEVSEG_BLINK_EN
          blink_mask <= bus.writedata[CTRL_MASK_LSB +: 8];
          blink_div  <= bus.writedata[CTRL_DIV_LSB +: 4];
`endif
        end
        ADDR_DIGITS:   digits_q   <= bus.writedata[4*NUM_DIGITS-1:0];
        ADDR_PRESCALE: prescale_q <= bus.writedata[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL: begin
        bus.readdata[CTRL_EN_BIT]  = ctrl_en;
        bus.readdata[CTRL_RAW_BIT] = ctrl_raw;
`ifdef SEVSEG_BLINK_EN
        bus.readdata[CTRL_MASK_LSB +: 8] = blink_mask;
        bus.readdata[CTRL_DIV_LSB +: 4]  = blink_div;
`endif
      end
      ADDR_DIGITS:   bus.readdata[4*NUM_DIGITS-1:0] = digits_q;
      ADDR_PRESCALE: bus.readdata[15:0] = prescale_q;
      default:       bus.readdata[5:0] = {blink_phase, state, index};
    endcase
  end

  // Timer control: SHOW entry loads PRESCALE, SHOW exit loads the gap length.
  always_comb begin
    t_load  = 1'b0;
    t_clear = 1'b0;
    t_val   = prescale_q;
    if (!ctrl_en) begin
      t_clear = 1'b1;
    end else begin
      case (state)
        ST_OFF:  t_load = 1'b1;
        ST_SHOW: begin
          t_load = t_done;
          t_val  = 16'(GAP_CYCLES - 1);
        end
        ST_GAP:  t_load = t_done;
        default: t_clear = 1'b1;
      endcase
    end
  end

  sevseg_dwell_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_val (t_val),
    .load     (t_load),
    .clear    (t_clear),
    .done     (t_done)
  );

  assign next_index = (index == IDX_W'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;

  always_comb begin
    show_seg = ctrl_raw ? digits_ext[6:0]
                        : hex_to_seg(digits_ext[{index, 2'b00} +: 4]);
`ifdef SEVSEG_BLINK_EN
    if (blink_mask[index] && blink_phase) show_seg = '0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_OFF;
      index      <= '0;
      seg_q      <= '0;
      digit_en_q <= '0;
`ifdef SEVSEG_BLINK_EN
      blink_phase <= 1'b0;
      frame_cnt   <= '0;
`endif
    end else begin
      // Outputs follow the current state/index one cycle later.
      seg_q      <= '0;
      digit_en_q <= '0;
      if (state == ST_SHOW) begin
        seg_q      <= show_seg;
        digit_en_q <= NUM_DIGITS'(1) << index;
      end

      if (!ctrl_en) begin
        state <= ST_OFF;
        index <= '0;
`ifdef SEVSEG_BLINK_EN
        blink_phase <= 1'b0;
        frame_cnt   <= '0;
`endif
      end else begin
        case (state)
          ST_OFF:  state <= ST_SHOW;
          ST_SHOW: if (t_done) state <= ST_GAP;
          ST_GAP: begin
            if (t_done) begin
              state <= ST_SHOW;
              index <= next_index;
`ifdef SEVSEG_BLINK_EN
              // A frame completes when the index wraps back to digit 0.
              if (index == IDX_W'(NUM_DIGITS - 1)) begin
                if (frame_cnt == (16'd1 << blink_div) - 16'd1) begin
                  frame_cnt   <= '0;
                  blink_phase <= ~blink_phase;
                end else begin
                  frame_cnt <= frame_cnt + 16'd1;
                end
              end
`endif
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

  assign seg_out   = seg_q ^ {7{INV}};
  assign digit_en  = digit_en_q ^ {NUM_DIGITS{INV}};
  assign dbg_state = state;

endmodule
